// File: rtl/cube_pkg.sv
// ----------------------------------------------------------------------------
// cube_pkg
// Shared types and helpers for the cube move history sequencer.
//   - face codes FACE_0..FACE_5 and NUM_FACES
//   - rotation codes as carried on the user/move interface
//   - move_t: 5-bit compact history entry {face, rot}
//   - rot_inverse / rot_to_qturns helpers
//   - FSM state and pending-operation enums
// No ports (package).
// ----------------------------------------------------------------------------
package cube_pkg;

   typedef enum logic [2:0] {
      FACE_0 = 3'd0,
      FACE_1 = 3'd1,
      FACE_2 = 3'd2,
      FACE_3 = 3'd3,
      FACE_4 = 3'd4,
      FACE_5 = 3'd5
   } face_e;

   localparam logic [2:0] NUM_FACES = 3'd6;

   typedef enum logic [1:0] {
      ROT_NONE = 2'b00,
      ROT_CW   = 2'b01,
      ROT_CCW  = 2'b10,
      ROT_DBL  = 2'b11
   } rot_e;

   typedef struct packed {
      logic [2:0] face;
      logic [1:0] rot;
   } move_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_SCRAMBLE
   } state_e;

   // Which history operation the command in flight will commit.
   typedef enum logic [1:0] {
      OP_MOVE,
      OP_UNDO,
      OP_REDO
   } op_e;

   // Undoing a quarter turn means turning the other way; a half turn is
   // its own inverse.
   function automatic logic [1:0] rot_inverse(input logic [1:0] rot);
      case (rot)
         ROT_CW:  return ROT_CCW;
         ROT_CCW: return ROT_CW;
         default: return rot;
      endcase
   endfunction

   // Cube engine expects clockwise quarter-turn counts.
   function automatic logic [2:0] rot_to_qturns(input logic [1:0] rot);
      case (rot)
         ROT_CW:  return 3'd1;
         ROT_CCW: return 3'd3;
         ROT_DBL: return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/cube_hist_ram.sv
// ----------------------------------------------------------------------------
// cube_hist_ram
// DEPTH x 5-bit move history storage. One write port, one read port with a
// registered (1-cycle) read. Contents are not reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   move entry to store
//   rd_addr  in   read address, sampled every cycle
//   rd_data  out  entry at rd_addr from the previous cycle
// ----------------------------------------------------------------------------
module cube_hist_ram
   import cube_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  move_t         wr_data,
   input  logic [AW-1:0] rd_addr,
   output move_t         rd_data
);

   move_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/cube_move_history.sv
// ----------------------------------------------------------------------------
// cube_move_history
// Move sequencer between user/scramble controls and the cube engine. Keeps a
// circular history of compact move codes for multi-level undo/redo, runs
// SCRAMBLE_LEN-move random scrambles, and issues one command at a time over
// a valid/ready handshake. move_count saturates at CNT_MAX.
// Optional build macro: CUBE_HIST_REDO_EN (enables redo; otherwise redo_req
// is ignored and redo_level is always 0).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   move_req/face/rot         manual move request and its fields
//   undo_req, redo_req        history navigation pulses
//   scramble_req, clear_req   scramble start / history flush pulses
//   rand_face, rand_rot       random move source for scrambles
//   cmd_valid/face/rot        command to the cube engine (rot = quarter turns)
//   cmd_ready                 engine accepts the command
//   busy, scrambling          status
//   move_count                saturating user move counter
//   hist_level, redo_level    undoable / redoable entry counts
// ----------------------------------------------------------------------------
module cube_move_history
   import cube_pkg::*;
#(
   parameter int DEPTH        = 64,
   parameter int SCRAMBLE_LEN = 20,
   parameter int CNT_W        = 10,
   parameter int CNT_MAX      = 999,
   localparam int PW = $clog2(DEPTH),
   localparam int LW = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             move_req,
   input  logic [2:0]       move_face,
   input  logic [1:0]       move_rot,
   input  logic             undo_req,
   input  logic             redo_req,
   input  logic             scramble_req,
   input  logic             clear_req,
   input  logic [2:0]       rand_face,
   input  logic [1:0]       rand_rot,
   output logic             cmd_valid,
   output logic [2:0]       cmd_face,
   output logic [2:0]       cmd_rot,
   input  logic             cmd_ready,
   output logic             busy,
   output logic             scrambling,
   output logic [CNT_W-1:0] move_count,
   output logic [LW-1:0]    hist_level,
   output logic [LW-1:0]    redo_level
);

`ifdef CUBE_HIST_REDO_EN
   localparam bit REDO_EN = 1'b1;
`else
   localparam bit REDO_EN = 1'b0;
`endif

   state_e           state_reg, state_next;
   op_e              op_reg, op_next;
   logic             cmd_valid_reg, cmd_valid_next;
   logic [2:0]       cmd_face_reg, cmd_face_next;
   logic [2:0]       cmd_rot_reg, cmd_rot_next;
   move_t            entry_reg, entry_next;
   logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [LW-1:0]    hist_level_reg, hist_level_next;
   logic [LW-1:0]    redo_level_reg, redo_level_next;
   logic [CNT_W-1:0] move_count_reg, move_count_next;
   logic [7:0]       scr_cnt_reg, scr_cnt_next;

   logic             ram_we;
   logic [PW-1:0]    rd_addr;
   move_t            rd_data;
   logic [2:0]       scr_face;
   logic [2:0]       scr_rot;
   logic [CNT_W-1:0] count_inc;
   logic [CNT_W-1:0] count_dec;

   cube_hist_ram #(.DEPTH(DEPTH), .AW(PW)) u_ram (
      .clk     (clk),
      .wr_en   (ram_we),
      .wr_addr (wr_ptr_reg),
      .wr_data (entry_reg),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // The read is launched in the request cycle so the entry is ready while
   // in FETCH; undo needs the newest entry, redo the one just past it.
   assign rd_addr = undo_req ? wr_ptr_reg - PW'(1) : wr_ptr_reg;

   assign scr_face = (rand_face >= NUM_FACES) ? rand_face - NUM_FACES : rand_face;

   always_comb begin
      case (rand_rot)
         2'b01:   scr_rot = 3'd3;
         2'b10:   scr_rot = 3'd2;
         default: scr_rot = 3'd1;
      endcase
   end

   assign count_inc = (move_count_reg == CNT_W'(CNT_MAX)) ? move_count_reg
                                                          : move_count_reg + CNT_W'(1);
   assign count_dec = (move_count_reg == '0) ? move_count_reg
                                             : move_count_reg - CNT_W'(1);

   always_comb begin
      state_next      = state_reg;
      op_next         = op_reg;
      cmd_valid_next  = cmd_valid_reg;
      cmd_face_next   = cmd_face_reg;
      cmd_rot_next    = cmd_rot_reg;
      entry_next      = entry_reg;
      wr_ptr_next     = wr_ptr_reg;
      hist_level_next = hist_level_reg;
      redo_level_next = redo_level_reg;
      move_count_next = move_count_reg;
      scr_cnt_next    = scr_cnt_reg;
      ram_we          = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (clear_req) begin
               wr_ptr_next     = '0;
               hist_level_next = '0;
               redo_level_next = '0;
               move_count_next = '0;
            end else if (scramble_req) begin
               state_next      = ST_SCRAMBLE;
               wr_ptr_next     = '0;
               hist_level_next = '0;
               redo_level_next = '0;
               move_count_next = '0;
               scr_cnt_next    = '0;
               cmd_valid_next  = 1'b1;
               cmd_face_next   = scr_face;
               cmd_rot_next    = scr_rot;
            end else if (undo_req) begin
               if (hist_level_reg != '0) begin
                  state_next = ST_FETCH;
                  op_next    = OP_UNDO;
               end
            end else if (REDO_EN && redo_req) begin
               if (redo_level_reg != '0) begin
                  state_next = ST_FETCH;
                  op_next    = OP_REDO;
               end
            end else if (move_req) begin
               if (move_rot != ROT_NONE && move_face < NUM_FACES) begin
                  state_next     = ST_ISSUE;
                  op_next        = OP_MOVE;
                  entry_next     = '{face: move_face, rot: move_rot};
                  cmd_valid_next = 1'b1;
                  cmd_face_next  = move_face;
                  cmd_rot_next   = rot_to_qturns(move_rot);
               end
            end
         end

         ST_FETCH: begin
            state_next     = ST_ISSUE;
            cmd_valid_next = 1'b1;
            cmd_face_next  = rd_data.face;
            cmd_rot_next   = (op_reg == OP_UNDO) ? rot_to_qturns(rot_inverse(rd_data.rot))
                                                 : rot_to_qturns(rd_data.rot);
         end

         ST_ISSUE: begin
            if (cmd_valid_reg && cmd_ready) begin
               cmd_valid_next = 1'b0;
               state_next     = ST_IDLE;
               case (op_reg)
                  OP_MOVE: begin
                     ram_we          = 1'b1;
                     wr_ptr_next     = wr_ptr_reg + PW'(1);
                     redo_level_next = '0;
                     if (hist_level_reg != LW'(DEPTH)) begin
                        hist_level_next = hist_level_reg + LW'(1);
                     end
                     move_count_next = count_inc;
                  end
                  OP_UNDO: begin
                     wr_ptr_next     = wr_ptr_reg - PW'(1);
                     hist_level_next = hist_level_reg - LW'(1);
                     if (REDO_EN) begin
                        redo_level_next = redo_level_reg + LW'(1);
                     end
                     move_count_next = count_dec;
                  end
                  default: begin
                     wr_ptr_next     = wr_ptr_reg + PW'(1);
                     hist_level_next = hist_level_reg + LW'(1);
                     redo_level_next = redo_level_reg - LW'(1);
                     move_count_next = count_inc;
                  end
               endcase
            end
         end

         ST_SCRAMBLE: begin
            // Random fields are captured only when cmd_valid rises, so the
            // command stays stable while the engine stalls.
            if (!cmd_valid_reg) begin
               cmd_valid_next = 1'b1;
               cmd_face_next  = scr_face;
               cmd_rot_next   = scr_rot;
            end else if (cmd_ready) begin
               cmd_valid_next = 1'b0;
               scr_cnt_next   = scr_cnt_reg + 8'd1;
               if (scr_cnt_reg == 8'(SCRAMBLE_LEN - 1)) begin
                  state_next = ST_IDLE;
               end
            end
         end

         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         op_reg         <= OP_MOVE;
         cmd_valid_reg  <= 1'b0;
         cmd_face_reg   <= '0;
         cmd_rot_reg    <= '0;
         entry_reg      <= '0;
         wr_ptr_reg     <= '0;
         hist_level_reg <= '0;
         redo_level_reg <= '0;
         move_count_reg <= '0;
         scr_cnt_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         op_reg         <= op_next;
         cmd_valid_reg  <= cmd_valid_next;
         cmd_face_reg   <= cmd_face_next;
         cmd_rot_reg    <= cmd_rot_next;
         entry_reg      <= entry_next;
         wr_ptr_reg     <= wr_ptr_next;
         hist_level_reg <= hist_level_next;
         redo_level_reg <= redo_level_next;
         move_count_reg <= move_count_next;
         scr_cnt_reg    <= scr_cnt_next;
      end
   end

   assign cmd_valid  = cmd_valid_reg;
   assign cmd_face   = cmd_face_reg;
   assign cmd_rot    = cmd_rot_reg;
   assign busy       = (state_reg != ST_IDLE);
   assign scrambling = (state_reg == ST_SCRAMBLE);
   assign move_count = move_count_reg;
   assign hist_level = hist_level_reg;
   assign redo_level = redo_level_reg;

endmodule

// File: tb/tb_cube_move_history.sv
// ----------------------------------------------------------------------------
// tb_cube_move_history
// Randomized self-checking bench for cube_move_history (DEPTH=4,
// SCRAMBLE_LEN=3, 4-bit counter saturating at 9). The reference model keeps
// the undo history and redo list as plain stacks of moves; commands are
// expected as clockwise quarter-turn counts, undo as (4 - q) mod 4.
// Honours CUBE_HIST_REDO_EN the same way as the design.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cube_move_history;

   localparam int DEPTH   = 4;
   localparam int SLEN    = 3;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 9;
   localparam int LW      = $clog2(DEPTH) + 1;

`ifdef CUBE_HIST_REDO_EN
   localparam bit REDO_EN = 1'b1;
`else
   localparam bit REDO_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             move_req = 1'b0;
   logic [2:0]       move_face = '0;
   logic [1:0]       move_rot = '0;
   logic             undo_req = 1'b0;
   logic             redo_req = 1'b0;
   logic             scramble_req = 1'b0;
   logic             clear_req = 1'b0;
   logic [2:0]       rand_face = '0;
   logic [1:0]       rand_rot = '0;
   logic             cmd_valid;
   logic [2:0]       cmd_face;
   logic [2:0]       cmd_rot;
   logic             cmd_ready = 1'b0;
   logic             busy;
   logic             scrambling;
   logic [CNT_W-1:0] move_count;
   logic [LW-1:0]    hist_level;
   logic [LW-1:0]    redo_level;

   always #5 clk = ~clk;

   cube_move_history #(
      .DEPTH(DEPTH), .SCRAMBLE_LEN(SLEN), .CNT_W(CNT_W), .CNT_MAX(CNT_MAX)
   ) dut (
      .clk(clk), .rst(rst),
      .move_req(move_req), .move_face(move_face), .move_rot(move_rot),
      .undo_req(undo_req), .redo_req(redo_req),
      .scramble_req(scramble_req), .clear_req(clear_req),
      .rand_face(rand_face), .rand_rot(rand_rot),
      .cmd_valid(cmd_valid), .cmd_face(cmd_face), .cmd_rot(cmd_rot),
      .cmd_ready(cmd_ready), .busy(busy), .scrambling(scrambling),
      .move_count(move_count), .hist_level(hist_level), .redo_level(redo_level)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: entries encoded as face*4 + rot (user rotation code).
   int hist_q[$];
   int redo_q[$];
   int exp_count = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int qt(input int r);
      case (r)
         1:       return 1;
         2:       return 3;
         3:       return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int scr_face_of(input int f);
      return (f > 5) ? f - 6 : f;
   endfunction

   function automatic int scr_rot_of(input int r);
      case (r)
         1:       return 3;
         2:       return 2;
         default: return 1;
      endcase
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, cmd_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_scr"}, scrambling, 0);
      chk({tag, "_hist"}, hist_level, hist_q.size());
      chk({tag, "_redo"}, redo_level, redo_q.size());
      chk({tag, "_count"}, move_count, exp_count);
   endtask

   // Expects a command on display now; stalls, then handshakes.
   task automatic handshake(input string tag, input int ef, input int er, input int stall);
      chk({tag, "_valid"}, cmd_valid, 1);
      chk({tag, "_face"}, cmd_face, ef);
      chk({tag, "_rot"}, cmd_rot, er);
      for (int i = 0; i < stall; i++) begin
         rand_face = 3'($urandom);
         rand_rot  = 2'($urandom);
         cmd_ready = 1'b0;
         tick();
         chk({tag, "_stall_valid"}, cmd_valid, 1);
         chk({tag, "_stall_face"}, cmd_face, ef);
         chk({tag, "_stall_rot"}, cmd_rot, er);
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk({tag, "_post_valid"}, cmd_valid, 0);
   endtask

   task automatic apply(input bit c, input bit s, input bit u, input bit r, input bit m,
                        input int face, input int rot, input int stall);
      int kind;
      int e;
      int sf;
      int sr;
      if (c)                 kind = 1;
      else if (s)            kind = 2;
      else if (u)            kind = (hist_q.size() > 0) ? 3 : 0;
      else if (r && REDO_EN) kind = (redo_q.size() > 0) ? 4 : 0;
      else if (m)            kind = (rot != 0 && face < 6) ? 5 : 0;
      else                   kind = 0;

      clear_req    = c;
      scramble_req = s;
      undo_req     = u;
      redo_req     = r;
      move_req     = m;
      move_face    = 3'(face);
      move_rot     = 2'(rot);
      rand_face    = 3'($urandom);
      rand_rot     = 2'($urandom);
      sf           = int'(rand_face);
      sr           = int'(rand_rot);
      cmd_ready    = 1'($urandom_range(0, 1));
      tick();
      {clear_req, scramble_req, undo_req, redo_req, move_req} = '0;
      cmd_ready = 1'b0;

      case (kind)
         1: begin
            hist_q.delete();
            redo_q.delete();
            exp_count = 0;
            check_idle("clear");
         end
         2: begin
            hist_q.delete();
            redo_q.delete();
            exp_count = 0;
            chk("scr_start", scrambling, 1);
            chk("scr_hist0", hist_level, 0);
            chk("scr_count0", move_count, 0);
            for (int k = 0; k < SLEN; k++) begin
               if (k > 0) begin
                  rand_face = 3'($urandom);
                  rand_rot  = 2'($urandom);
                  sf        = int'(rand_face);
                  sr        = int'(rand_rot);
                  tick();
               end
               handshake("scr", scr_face_of(sf), scr_rot_of(sr), stall);
               if (k < SLEN - 1) chk("scr_active", scrambling, 1);
            end
            check_idle("scr_end");
            $display("scramble: %0d moves, stall %0d", SLEN, stall);
         end
         3, 4: begin
            e = (kind == 3) ? hist_q.pop_back() : redo_q.pop_back();
            chk("fetch_valid", cmd_valid, 0);
            chk("fetch_busy", busy, 1);
            cmd_ready = 1'($urandom_range(0, 1));
            tick();
            cmd_ready = 1'b0;
            if (kind == 3) begin
               handshake("undo", e / 4, (4 - qt(e % 4)) % 4, stall);
               if (REDO_EN) redo_q.push_back(e);
               if (exp_count > 0) exp_count--;
            end else begin
               handshake("redo", e / 4, qt(e % 4), stall);
               hist_q.push_back(e);
               if (exp_count < CNT_MAX) exp_count++;
            end
            check_idle(kind == 3 ? "undo_done" : "redo_done");
            $display("%s: face %0d rot %0d, hist %0d redo %0d count %0d",
                     kind == 3 ? "undo" : "redo", e / 4, e % 4,
                     hist_q.size(), redo_q.size(), exp_count);
         end
         5: begin
            handshake("move", face, qt(rot), stall);
            hist_q.push_back(face * 4 + rot);
            if (hist_q.size() > DEPTH) void'(hist_q.pop_front());
            redo_q.delete();
            if (exp_count < CNT_MAX) exp_count++;
            check_idle("move_done");
            $display("move: face %0d rot %0d, hist %0d count %0d",
                     face, rot, hist_q.size(), exp_count);
         end
         default: begin
            check_idle("ignored");
            $display("ignored: c%0d s%0d u%0d r%0d m%0d face %0d rot %0d",
                     c, s, u, r, m, face, rot);
         end
      endcase
   endtask

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      check_idle("reset");

      // Single move, then the two-move undo/redo walk-through.
      apply(0, 0, 0, 0, 1, 2, 1, 0);
      chk("t1_hist", hist_level, 1);
      chk("t1_count", move_count, 1);
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 1, 0, 1, 1);
      apply(0, 0, 0, 0, 1, 1, 2, 0);
      apply(0, 0, 1, 0, 0, 0, 0, 2);
      apply(0, 0, 1, 0, 0, 0, 0, 0);
      chk("t2_hist", hist_level, 0);
      apply(0, 0, 0, 1, 0, 0, 0, 0);
      apply(0, 0, 0, 1, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 1, 3, 3, 0);
      chk("t3_redo", redo_level, 0);

      // Wrap-around: five moves into four slots, five undos.
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, 1, i, 1 + (i % 3), 0);
      chk("t4_full", hist_level, DEPTH);
      for (int i = 0; i < 5; i++) apply(0, 0, 1, 0, 0, 0, 0, 0);
      chk("t4_empty", hist_level, 0);

      // Invalid moves.
      apply(0, 0, 0, 0, 1, 6, 1, 0);
      apply(0, 0, 0, 0, 1, 2, 0, 0);

      // Scramble with two-cycle stalls.
      apply(0, 1, 0, 0, 0, 0, 0, 2);

      // Undo and move together: undo wins.
      apply(0, 0, 0, 0, 1, 5, 2, 0);
      apply(0, 0, 1, 0, 1, 4, 1, 0);

      // Reset while a command is pending.
      move_req  = 1'b1;
      move_face = 3'd4;
      move_rot  = 2'd1;
      tick();
      move_req = 1'b0;
      chk("rst_pre_valid", cmd_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      hist_q.delete();
      redo_q.delete();
      exp_count = 0;
      check_idle("rst_mid");

      // Random traffic.
      for (int t = 0; t < 300; t++) begin
         apply($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
